// File: rtl/apu_reg_writer.sv
// Two-byte (address, data) frame parser driving the APU square-channel registers $4000-$4007,
// plus the 240 Hz / 120 Hz frame-sequencer ticks. Optional macro: APU_WRITE_TIMEOUT_EN.
module apu_reg_writer #(
    parameter int unsigned FRAME_DIV = 7457,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] sq1_reg0,
    output logic [7:0] sq1_reg1,
    output logic [7:0] sq1_reg2,
    output logic [7:0] sq1_reg3,
    output logic [7:0] sq2_reg0,
    output logic [7:0] sq2_reg1,
    output logic [7:0] sq2_reg2,
    output logic [7:0] sq2_reg3,
    output logic       sq1_event,
    output logic       sq2_event,
    output logic       enable_240hz,
    output logic       enable_120hz,
    output logic       frame_err
);

    localparam int unsigned DIV_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [4:0] OFFSET_CTRL = 5'h17;

    typedef enum logic [1:0] {StIdle, StData, StCommit} state_e;

    state_e           state_q;
    logic [4:0]       offset_q;
    logic [7:0]       sq_regs_q [8];
    logic             rx_ready_q;
    logic             sq1_event_q;
    logic             sq2_event_q;
    logic             frame_err_q;
    logic [DIV_W-1:0] div_q;
    logic             phase_q;
    logic             en240_q;
    logic             en120_q;

    logic accept;
    logic ctrl_wr;

    assign accept  = rx_valid && rx_ready_q;
    assign ctrl_wr = (state_q == StData) && accept && (offset_q == OFFSET_CTRL);

`ifdef APU_WRITE_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            offset_q    <= '0;
            rx_ready_q  <= 1'b0;
            sq1_event_q <= 1'b0;
            sq2_event_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                sq_regs_q[i] <= '0;
            end
`ifdef APU_WRITE_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            rx_ready_q  <= 1'b1;
            sq1_event_q <= 1'b0;
            sq2_event_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (rx_data[7]) begin
                            offset_q <= rx_data[4:0];
                            state_q  <= StData;
`ifdef APU_WRITE_TIMEOUT_EN
                            to_cnt_q <= '0;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        // Write lands on the accept edge so the register is valid with the event.
                        if (offset_q[4:3] == 2'b00) begin
                            sq_regs_q[offset_q[2:0]] <= rx_data;
                        end
                        sq1_event_q <= (offset_q == 5'd3);
                        sq2_event_q <= (offset_q == 5'd7);
                        rx_ready_q  <= 1'b0;
                        state_q     <= StCommit;
                    end
`ifdef APU_WRITE_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        frame_err_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                StCommit: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Frame sequencer; a frame-control write takes priority over a natural terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            phase_q <= 1'b0;
            en240_q <= 1'b0;
            en120_q <= 1'b0;
        end else if (ctrl_wr) begin
            div_q   <= '0;
            phase_q <= 1'b0;
            en240_q <= rx_data[7];
            en120_q <= rx_data[7];
        end else if (div_q == DIV_LAST) begin
            div_q   <= '0;
            phase_q <= ~phase_q;
            en240_q <= 1'b1;
            en120_q <= phase_q;
        end else begin
            div_q   <= div_q + 1'b1;
            en240_q <= 1'b0;
            en120_q <= 1'b0;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign sq1_reg0     = sq_regs_q[0];
    assign sq1_reg1     = sq_regs_q[1];
    assign sq1_reg2     = sq_regs_q[2];
    assign sq1_reg3     = sq_regs_q[3];
    assign sq2_reg0     = sq_regs_q[4];
    assign sq2_reg1     = sq_regs_q[5];
    assign sq2_reg2     = sq_regs_q[6];
    assign sq2_reg3     = sq_regs_q[7];
    assign sq1_event    = sq1_event_q;
    assign sq2_event    = sq2_event_q;
    assign enable_240hz = en240_q;
    assign enable_120hz = en120_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_apu_reg_writer.sv
// Directed bench for apu_reg_writer with FRAME_DIV=8, TIMEOUT=16; honours APU_WRITE_TIMEOUT_EN.
module tb_apu_reg_writer;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] sq1_reg0, sq1_reg1, sq1_reg2, sq1_reg3;
    logic [7:0] sq2_reg0, sq2_reg1, sq2_reg2, sq2_reg3;
    logic       sq1_event, sq2_event;
    logic       enable_240hz, enable_120hz;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    apu_reg_writer #(
        .FRAME_DIV(8),
        .TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .sq1_reg0    (sq1_reg0),
        .sq1_reg1    (sq1_reg1),
        .sq1_reg2    (sq1_reg2),
        .sq1_reg3    (sq1_reg3),
        .sq2_reg0    (sq2_reg0),
        .sq2_reg1    (sq2_reg1),
        .sq2_reg2    (sq2_reg2),
        .sq2_reg3    (sq2_reg3),
        .sq1_event   (sq1_event),
        .sq2_event   (sq2_event),
        .enable_240hz(enable_240hz),
        .enable_120hz(enable_120hz),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents address then data; returns in the COMMIT cycle with rx_valid low.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = a;
        tick();
        rx_data = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [63:0] exp);
        check({tag, " sq1_reg0"}, {24'd0, sq1_reg0}, {24'd0, exp[7:0]});
        check({tag, " sq1_reg1"}, {24'd0, sq1_reg1}, {24'd0, exp[15:8]});
        check({tag, " sq1_reg2"}, {24'd0, sq1_reg2}, {24'd0, exp[23:16]});
        check({tag, " sq1_reg3"}, {24'd0, sq1_reg3}, {24'd0, exp[31:24]});
        check({tag, " sq2_reg0"}, {24'd0, sq2_reg0}, {24'd0, exp[39:32]});
        check({tag, " sq2_reg1"}, {24'd0, sq2_reg1}, {24'd0, exp[47:40]});
        check({tag, " sq2_reg2"}, {24'd0, sq2_reg2}, {24'd0, exp[55:48]});
        check({tag, " sq2_reg3"}, {24'd0, sq2_reg3}, {24'd0, exp[63:56]});
    endtask

    initial begin
        logic [63:0] regs_exp;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();

        // Reset state
        regs_exp = 64'h0;
        check_regs("reset", regs_exp);
        check("reset rx_ready", {31'd0, rx_ready}, 32'd0);
        check("reset sq1_event", {31'd0, sq1_event}, 32'd0);
        check("reset sq2_event", {31'd0, sq2_event}, 32'd0);
        check("reset en240", {31'd0, enable_240hz}, 32'd0);
        check("reset en120", {31'd0, enable_120hz}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;

        // Free-run: 240 Hz at 8,16,24,32,40; 120 Hz at 16,32
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) check("rx_ready after reset", {31'd0, rx_ready}, 32'd1);
            check($sformatf("freerun en240 c%0d", n), {31'd0, enable_240hz},
                  {31'd0, (n % 8) == 0});
            check($sformatf("freerun en120 c%0d", n), {31'd0, enable_120hz},
                  {31'd0, (n % 16) == 0});
        end

        // Frame 0x83, 0x5A -> sq1_reg3 with sq1_event
        send_frame(8'h83, 8'h5A);
        check("f1 sq1_reg3", {24'd0, sq1_reg3}, 32'h5A);
        check("f1 sq1_event", {31'd0, sq1_event}, 32'd1);
        check("f1 sq2_event", {31'd0, sq2_event}, 32'd0);
        check("f1 commit rx_ready", {31'd0, rx_ready}, 32'd0);
        // Byte presented during COMMIT must wait
        rx_valid = 1'b1;
        rx_data  = 8'h80;
        tick();
        check("f1 event one cycle", {31'd0, sq1_event}, 32'd0);
        check("idle rx_ready", {31'd0, rx_ready}, 32'd1);
        tick();
        rx_data = 8'hBF;
        tick();
        rx_valid = 1'b0;
        check("f2 sq1_reg0", {24'd0, sq1_reg0}, 32'hBF);
        check("f2 sq1_event", {31'd0, sq1_event}, 32'd0);
        tick();

        send_frame(8'h86, 8'h08);
        check("f3 sq2_reg2", {24'd0, sq2_reg2}, 32'h08);
        check("f3 sq1_event", {31'd0, sq1_event}, 32'd0);
        check("f3 sq2_event", {31'd0, sq2_event}, 32'd0);
        tick();

        // Bad address byte in IDLE
        rx_valid = 1'b1;
        rx_data  = 8'h12;
        tick();
        rx_valid = 1'b0;
        check("bad addr frame_err", {31'd0, frame_err}, 32'd1);
        tick();
        check("bad addr err once", {31'd0, frame_err}, 32'd0);
        regs_exp = 64'h00_08_00_00_5A_00_00_BF;
        check_regs("bad addr", regs_exp);
        send_frame(8'h84, 8'h77);
        check("f4 sq2_reg0", {24'd0, sq2_reg0}, 32'h77);
        tick();

        // Frame-control write with bit7=1: both enables in COMMIT, re-phased divider
        send_frame(8'h97, 8'h80);
        check("fc1 en240 commit", {31'd0, enable_240hz}, 32'd1);
        check("fc1 en120 commit", {31'd0, enable_120hz}, 32'd1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("fc1 en240 +%0d", i), {31'd0, enable_240hz}, 32'd0);
        end
        tick();
        check("fc1 en240 +8", {31'd0, enable_240hz}, 32'd1);
        check("fc1 en120 +8", {31'd0, enable_120hz}, 32'd0);

        // Frame-control write with bit7=0 landing on a natural terminal count: suppressed
        repeat (6) tick();
        send_frame(8'h97, 8'h00);
        check("fc2 en240 suppressed", {31'd0, enable_240hz}, 32'd0);
        check("fc2 en120 suppressed", {31'd0, enable_120hz}, 32'd0);
        repeat (7) tick();
        check("fc2 en240 +7", {31'd0, enable_240hz}, 32'd0);
        tick();
        check("fc2 en240 +8", {31'd0, enable_240hz}, 32'd1);
        check("fc2 en120 phase reset", {31'd0, enable_120hz}, 32'd0);

        // Unmapped offset: data consumed, nothing written, no error
        send_frame(8'h88, 8'h33);
        check("unmapped frame_err", {31'd0, frame_err}, 32'd0);
        regs_exp = 64'h00_08_00_77_5A_00_00_BF;
        check_regs("unmapped", regs_exp);
        tick();

        // Stalled data byte
        rx_valid = 1'b1;
        rx_data  = 8'h81;
        tick();
        rx_valid = 1'b0;
`ifdef APU_WRITE_TIMEOUT_EN
        repeat (15) tick();
        check("timeout early", {31'd0, frame_err}, 32'd0);
        tick();
        check("timeout frame_err", {31'd0, frame_err}, 32'd1);
        tick();
        check("timeout err once", {31'd0, frame_err}, 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tick();
        rx_valid = 1'b0;
        check("post-timeout bad addr", {31'd0, frame_err}, 32'd1);
        check("post-timeout sq1_reg1", {24'd0, sq1_reg1}, 32'h00);
        tick();
`else
        repeat (40) tick();
        check("no timeout frame_err", {31'd0, frame_err}, 32'd0);
        check("no timeout rx_ready", {31'd0, rx_ready}, 32'd1);
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        tick();
        rx_valid = 1'b0;
        check("late data sq1_reg1", {24'd0, sq1_reg1}, 32'h44);
        tick();
`endif

        // Reset mid-frame drops the partial frame
        rx_valid = 1'b1;
        rx_data  = 8'h82;
        tick();
        rx_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("midreset rx_ready", {31'd0, rx_ready}, 32'd0);
        regs_exp = 64'h0;
        check_regs("midreset", regs_exp);
        rst = 1'b0;
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        tick();
        rx_valid = 1'b0;
        check("midreset byte is addr", {31'd0, frame_err}, 32'd1);
        check("midreset sq1_reg2", {24'd0, sq1_reg2}, 32'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
